// File: rtl/bus_rr_arbiter.sv
// Four-master round-robin bus arbiter with active-low handshakes and a
// bounded-hold rule that preempts a long-running owner at a transaction boundary.
module bus_rr_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  input  logic       m_rdy_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {IDLE, OWNED} state_e;

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

  state_e            state_q, state_d;
  logic [3:0]        grnt_q, grnt_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              preempt_q, preempt_d;

  logic [3:0] req;
  logic [3:0] others;
  logic       owner_req;
  logic       hold_expired;

  // First asserted request in the order ptr, ptr+1, ptr+2, ptr+3; callers
  // only use the result when at least one bit of req is set.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + i[1:0];
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign req          = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign others       = req & ~(4'b0001 << owner_q);
  assign owner_req    = req[owner_q];
  assign hold_expired = (HOLD_MAX != 0) && (hold_q == HOLD_LIM);

  always_comb begin
    state_d   = state_q;
    grnt_d    = grnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = rr_pick(req, ptr_q);
          grnt_d  = 4'b0001 << owner_d;
          ptr_d   = owner_d + 2'd1;
          hold_d  = '0;
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (!owner_req) begin
          // The releasing owner's request is already low, so a plain pick
          // over all requests hands straight over with no idle cycle.
          if (|req) begin
            owner_d = rr_pick(req, ptr_q);
            grnt_d  = 4'b0001 << owner_d;
            ptr_d   = owner_d + 2'd1;
            hold_d  = '0;
          end else begin
            grnt_d  = '0;
            hold_d  = '0;
            state_d = IDLE;
          end
        end else if (hold_expired && (|others) && !m_rdy_) begin
          owner_d   = rr_pick(others, ptr_q);
          grnt_d    = 4'b0001 << owner_d;
          ptr_d     = owner_d + 2'd1;
          hold_d    = '0;
          preempt_d = 1'b1;
        end else if (|others) begin
          hold_d = (hold_q == HOLD_LIM) ? hold_q : hold_q + HOLD_W'(1);
        end else begin
          hold_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grnt_q    <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grnt_q    <= grnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = ~grnt_q;
  assign owner   = owner_q;
  assign busy    = (state_q == OWNED);
  assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: three instances (hold limits 16, 4, 0) share one
// stimulus and are each checked every cycle against a behavioural model.
module tb_bus_rr_arbiter;

  localparam int NI = 3;
  localparam int HM [NI] = '{16, 4, 0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req_n = 4'b1111;
  logic rdy_n = 1'b0;

  logic [NI-1:0][3:0] gn;
  logic [NI-1:0][1:0] ow;
  logic [NI-1:0]      bz;
  logic [NI-1:0]      pe;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    bus_rr_arbiter #(.HOLD_MAX(HM[k]), .HOLD_W(5)) dut (
      .clk      (clk),
      .reset    (reset),
      .m0_req_  (req_n[0]),
      .m1_req_  (req_n[1]),
      .m2_req_  (req_n[2]),
      .m3_req_  (req_n[3]),
      .m_rdy_   (rdy_n),
      .m0_grnt_ (gn[k][0]),
      .m1_grnt_ (gn[k][1]),
      .m2_grnt_ (gn[k][2]),
      .m3_grnt_ (gn[k][3]),
      .owner    (ow[k]),
      .busy     (bz[k]),
      .preempt  (pe[k])
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner is -1 when nobody holds the bus.
  int m_own  [NI] = '{-1, -1, -1};
  int m_ptr  [NI] = '{0, 0, 0};
  int m_hold [NI] = '{0, 0, 0};
  bit m_pre  [NI] = '{0, 0, 0};

  function automatic int rr_win(input logic [3:0] r, input int ptr, input int excl);
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (ptr + i) % 4;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NI; k++) begin
        m_own[k] <= -1; m_ptr[k] <= 0; m_hold[k] <= 0; m_pre[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        logic [3:0] r;
        int own, ptr, hold, w;
        bit pre, oth;
        r = ~req_n;
        own = m_own[k]; ptr = m_ptr[k]; hold = m_hold[k]; pre = 1'b0; w = -1;
        if (own < 0 || !r[own]) begin
          w = rr_win(r, ptr, -1);
          if (w < 0) own = -1;
        end else begin
          oth = 1'b0;
          for (int j = 0; j < 4; j++) if (j != own && r[j]) oth = 1'b1;
          if (HM[k] != 0 && hold == HM[k] && oth && !rdy_n) begin
            w = rr_win(r, ptr, own);
            pre = 1'b1;
          end else if (oth) begin
            if (hold < HM[k]) hold = hold + 1;
          end else begin
            hold = 0;
          end
        end
        if (w >= 0) begin
          own = w; ptr = (w + 1) % 4; hold = 0;
        end
        m_own[k] <= own; m_ptr[k] <= ptr; m_hold[k] <= hold; m_pre[k] <= pre;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      int eg;
      eg = (m_own[k] < 0) ? 15 : (15 & ~(1 << m_own[k]));
      chk($sformatf("i%0d grants", k), int'(gn[k]), eg);
      chk($sformatf("i%0d busy", k), int'(bz[k]), (m_own[k] >= 0) ? 1 : 0);
      chk($sformatf("i%0d preempt", k), int'(pe[k]), int'(m_pre[k]));
      if (m_own[k] >= 0) chk($sformatf("i%0d owner", k), int'(ow[k]), m_own[k]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_n = 4'b1111;
    rdy_n = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int ord [5] = '{0, 1, 2, 3, 0};

    // Reset state and single requester
    do_reset();
    chk("rst grants", int'(gn[0]), 15);
    chk("rst owner", int'(ow[0]), 0);
    chk("rst busy", int'(bz[0]), 0);
    chk("rst preempt", int'(pe[0]), 0);
    req_n = 4'b1011;
    step();
    chk("m2 grant", int'(gn[0]), 4'b1011);
    chk("m2 owner", int'(ow[0]), 2);
    chk("m2 busy", int'(bz[0]), 1);
    req_n = 4'b1111;
    step();
    chk("m2 release grants", int'(gn[0]), 15);
    chk("m2 release busy", int'(bz[0]), 0);

    // Rotation 0,1,2,3,0 with 3-cycle ownerships and no idle gap
    do_reset();
    req_n = 4'b0000;
    step();
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("rot%0d owner", g), int'(ow[0]), ord[g]);
      chk($sformatf("rot%0d busy", g), int'(bz[0]), 1);
      step();
      step();
      chk($sformatf("rot%0d held", g), int'(ow[0]), ord[g]);
      req_n[ord[g]] = 1'b1;
      step();
      chk($sformatf("rot%0d handover busy", g), int'(bz[0]), 1);
      req_n[ord[g]] = 1'b0;
    end
    req_n = 4'b1111;
    step();
    step();

    // HOLD_MAX=4 preemption at a ready boundary
    do_reset();
    req_n = 4'b1101;
    step();
    chk("hold m1 grant", int'(gn[1]), 4'b1101);
    req_n = 4'b0101;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("hold c%0d m1 kept", c), int'(gn[1]), 4'b1101);
      chk($sformatf("hold c%0d no preempt", c), int'(pe[1]), 0);
    end
    step();
    chk("preempt m3 grant", int'(gn[1]), 4'b0111);
    chk("preempt pulse", int'(pe[1]), 1);
    step();
    chk("preempt one cycle", int'(pe[1]), 0);
    req_n = 4'b1111;
    step();

    // HOLD_MAX=4 with the slave busy: no mid-transaction preemption
    do_reset();
    req_n = 4'b1101;
    rdy_n = 1'b1;
    step();
    req_n = 4'b0101;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("busy slave m1 kept", int'(gn[1]), 4'b1101);
    end
    rdy_n = 1'b0;
    step();
    chk("boundary m3 grant", int'(gn[1]), 4'b0111);
    chk("boundary preempt", int'(pe[1]), 1);
    req_n = 4'b1111;
    step();

    // HOLD_MAX=0 never preempts
    do_reset();
    req_n = 4'b1110;
    step();
    req_n = 4'b1100;
    for (int c = 0; c < 100; c++) begin
      step();
      chk("hm0 m0 kept", int'(gn[2]), 4'b1110);
      chk("hm0 no preempt", int'(pe[2]), 0);
    end
    req_n = 4'b1111;
    step();

    // Asynchronous reset while m3 owns, then restart from ptr=0
    do_reset();
    req_n = 4'b0111;
    step();
    chk("m3 owns", int'(gn[0]), 4'b0111);
    reset = 1'b1;
    #1;
    chk("async rst grants", int'(gn[0]), 15);
    chk("async rst busy", int'(bz[0]), 0);
    req_n = 4'b0101;
    step();
    reset = 1'b0;
    step();
    chk("post rst m1 first", int'(gn[0]), 4'b1101);
    chk("post rst owner", int'(ow[0]), 1);
    req_n = 4'b1111;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Round-robin arbiter for the shared AZPR bus. Grants bus ownership to one of four bus masters at a time.
- Sequences the master side of the bus slave multiplexer: the granted master drives address/control; the multiplexed read data and ready return to it.
- Adds a bounded-hold rule. A master holding the bus while others wait is preempted at a transaction boundary (m_rdy_ asserted) once its hold limit expires.
- All master-side handshake signals are active-low, consistent with the rest of the bus.

Parameters:
- HOLD_MAX, 16: consecutive owned cycles allowed while another master is waiting. Value 0 disables preemption.
- HOLD_W, 5: width of the hold counter. Must satisfy 2**HOLD_W > HOLD_MAX.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- m0_req_  input  1  master 0 bus request, active-low
- m1_req_  input  1  master 1 bus request, active-low
- m2_req_  input  1  master 2 bus request, active-low
- m3_req_  input  1  master 3 bus request, active-low
- m_rdy_  input  1  shared ready returned by the slave mux, active-low; marks a transaction boundary
- m0_grnt_  output  1  master 0 grant, active-low, registered
- m1_grnt_  output  1  master 1 grant, active-low, registered
- m2_grnt_  output  1  master 2 grant, active-low, registered
- m3_grnt_  output  1  master 3 grant, active-low, registered
- owner  output  2  index of current owner; valid only when busy=1
- busy  output  1  1 while some master holds a grant
- preempt  output  1  one-cycle pulse in the cycle a forced hand-over takes effect

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values:
  - all mN_grnt_ = 1 (disabled)
  - owner = 0, busy = 0, preempt = 0
  - internal priority pointer ptr = 0, hold_cnt = 0
- State machine: two states.
  - IDLE: no grant asserted.
  - OWNED: exactly one grant asserted.
  - At most one mN_grnt_ is low in any cycle (one-hot-low or all high).
- Round-robin pick:
  - Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first asserted request wins.
  - When a grant is issued to master k, ptr becomes k+1 mod 4.
- IDLE, any request asserted: grant the RR winner; grant is visible the next cycle (latency 1 cycle). State goes to OWNED, busy=1, owner=k, hold_cnt=0.
- IDLE, no request: remain in IDLE; outputs unchanged.
- OWNED, owner's req_ deasserted:
  - If any other request is asserted, switch the grant directly to the RR winner next cycle, with no idle gap. preempt stays 0.
  - Otherwise deassert all grants next cycle and go to IDLE.
- OWNED, owner's req_ still asserted:
  - hold_cnt increments each cycle that at least one other master requests. It saturates at HOLD_MAX.
  - hold_cnt is cleared when no other master is requesting.
- Preemption: HOLD_MAX != 0, hold_cnt == HOLD_MAX, another request pending, and m_rdy_ == 0 in the same cycle.
  - Next cycle the grant moves to the RR winner among the other masters (owner excluded), and preempt pulses 1 for that cycle.
  - If m_rdy_ stays 1, the owner keeps the bus indefinitely; the arbiter never preempts mid-transaction.
- Any grant change clears hold_cnt to 0.
- Simultaneous events: owner release takes precedence over preemption; release is reported with preempt=0.
- A request that drops before it is granted is simply not granted; no state is retained for it.
- Reset mid-ownership: grants drop immediately (asynchronous). After reset the arbitration restarts with ptr=0.
- preempt is never asserted in IDLE or during reset.

Test Plan:
- Reset, then m2_req_=0 alone -> m2_grnt_=0 one cycle later, owner=2, busy=1; after m2_req_=1, the next cycle has all grants 1 and busy=0.
- Right after reset, m0..m3_req_ all 0, each owner releasing after 3 cycles -> grant order 0,1,2,3,0, with no idle cycle between hand-overs.
- HOLD_MAX=4: m1 holds, m3 requests, m_rdy_=0 every cycle -> m3_grnt_=0 exactly 5 cycles after m3 first requests, preempt=1 for that single cycle, m1_grnt_=1.
- HOLD_MAX=4: same as above but m_rdy_=1 for 20 cycles -> m1 retains the bus throughout. The first cycle with m_rdy_=0 hands the bus to m3 the next cycle with preempt=1.
- HOLD_MAX=0: m0 holds for 100 cycles with m1 requesting and m_rdy_=0 -> no preemption, preempt stays 0.
- Reset asserted while m3 owns -> all mN_grnt_=1 immediately. With m1_req_ and m3_req_ both low after reset release, m1 is granted first (ptr=0).
